mux_rr_arbiter: RTL
===================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares the 32-input, 64-bit output-select mux among 32 requesters.
- Drives the mux's 6-bit select and a one-hot grant vector.
- Presents the mux output to one downstream consumer through a valid/ready handshake.
- Grants in bursts of up to MAX_BURST accepted beats, so no requester starves the others.

Parameters:
- N_SRC, 32, number of requesters; equals the mux input count.
- SEL_W, 6, select width; matches the mux select port.
- MAX_BURST, 4, maximum accepted beats per grant; legal range 1..15.

Ports:
- clk  input  1  single clock for the block.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- req  input  N_SRC  per-source request; bit i means source i has data on mux input i.
- out_ready  input  1  downstream accepts the current beat.
- select  output  SEL_W  mux select; only values 0..31 are ever driven.
- grant  output  N_SRC  one-hot current owner; all zeros when idle.
- out_valid  output  1  mux output is a valid beat from the granted source.
- busy  output  1  high in ACTIVE state.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, select=0, grant=0, out_valid=0, busy=0, ptr=0, beat_cnt=0.
  - Reset mid-burst aborts the burst immediately.
  - No beat is counted in the reset cycle.
- All state changes on the rising edge of clk; all outputs are registered.
- State IDLE:
  - If req==0: stay in IDLE; select holds its last value; grant=0.
  - Otherwise pick winner w = the first set req bit scanning ptr, ptr+1, ..., 31, 0, ..., ptr-1.
  - Next edge: select<=w, grant<=(1<<w), out_valid<=1, busy<=1, beat_cnt<=0, state<=ACTIVE.
  - Latency from req rising in IDLE to out_valid=1 is 1 cycle.
- State ACTIVE:
  - A beat is accepted in a cycle where out_valid && out_ready.
  - out_valid is never retracted before acceptance, even if req[w] drops meanwhile.
  - On each accepted beat: beat_cnt<=beat_cnt+1.
  - The burst ends on an accepted beat if beat_cnt+1==MAX_BURST or req[w]==0 in that cycle.
  - On burst end: ptr<=(w+1) mod 32 (31 wraps to 0), grant<=0, out_valid<=0, busy<=0, state<=IDLE.
  - select holds w through the end cycle and during IDLE.
  - There is exactly one dead cycle between bursts; re-arbitration happens from IDLE.
  - Without out_ready, ACTIVE holds indefinitely with no timeout.
- Fairness:
  - A source that ends its burst has the lowest priority in the next arbitration.
  - With all 32 requesting, grants rotate 0, 1, ..., 31, 0.
- Widths:
  - beat_cnt is 4 bits; ptr is 5 bits zero-extended into select.
  - select bit 5 is always 0.
- Simultaneous events:
  - A new req arriving while ACTIVE is only considered at the next IDLE arbitration.
  - req[w] dropping in the same cycle as the MAX_BURST-th acceptance ends the burst once, with a single ptr update.

Decomposition:
- Shared package:
  - state enum {IDLE, ACTIVE}.
  - N_SRC=32, SEL_W=6.
  - default MAX_BURST.
- Sub-module rr_pick (combinational):
  - inputs req[31:0], ptr[4:0].
  - outputs any, winner[4:0].
  - implementation: rotating priority encoder (rotate right by ptr, find first set bit, add ptr mod 32).
- Top level holds the FSM, counters and output registers.

Test Plan:
- Reset: assert rst with req=all ones, then release -> all outputs 0 during reset; 1 cycle after release select=0, grant=0x00000001, out_valid=1.
- Single source: req=1<<5, out_ready=1 constantly, MAX_BURST=4 -> 4 accepted beats with select=5, then 1 dead cycle, then a new burst on 5 (ptr=6 wraps round to 5).
- Rotation: req=0x80000001, ptr=0, out_ready=1 -> bursts to 0, then 31, then 0; select sequence 0, 31, 0 with one dead cycle between bursts.
- Backpressure: grant 3, out_ready=0 for 10 cycles while req[3] drops at cycle 2 -> out_valid stays 1 with select=3; the burst ends on the first accepted beat; ptr=4.
- Early end: req[7] held for 2 accepted beats then dropped with MAX_BURST=4 -> burst ends after the 2nd beat; grant=0 on the next cycle.
- Reset mid-burst: rst=1 at the 2nd beat of source 9 -> next cycle all outputs 0, ptr=0; with req=1<<9 still high after release, source 9 is re-granted.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and sizing for the round-robin mux arbiter.
package mux_rr_arbiter_pkg;

  localparam int N_SRC         = 32;
  localparam int SEL_W         = 6;
  localparam int PTR_W         = 5;
  localparam int CNT_W         = 4;
  localparam int MAX_BURST_DEF = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotating priority encoder.
// The first set request at or after ptr wins, wrapping from 31 back to 0.
module rr_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             any,
  output logic [PTR_W-1:0] winner
);

  logic [2*N_SRC-1:0] dbl_s;
  logic [N_SRC-1:0]   rot_s;
  logic [PTR_W-1:0]   idx_s;

  // Rotate the request vector right by ptr.
  // Find the lowest set bit, then undo the rotation.
  always_comb begin
    dbl_s = {req, req} >> ptr;
    rot_s = dbl_s[N_SRC-1:0];
    idx_s = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        idx_s = PTR_W'(i);
      end else begin
        idx_s = idx_s;
      end
    end
    any    = |req;
    winner = idx_s + ptr;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a 32-input mux.
// It grants bursts of up to MAX_BURST accepted beats per owner.
// One dead IDLE cycle separates consecutive bursts.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  input  logic             out_ready,
  output logic [SEL_W-1:0] select,
  output logic [N_SRC-1:0] grant,
  output logic             out_valid,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MAX_BURST_C = CNT_W'(MAX_BURST);
  localparam logic [N_SRC-1:0] ONE_HOT0    = {{(N_SRC-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [SEL_W-1:0] select_q;
  logic [N_SRC-1:0] grant_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] beat_cnt_q;

  logic             pick_any_s;
  logic [PTR_W-1:0] pick_winner_s;
  logic [PTR_W-1:0] owner_s;
  logic             beat_acc_s;
  logic             burst_end_s;

  rr_pick u_rr_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (pick_any_s),
    .winner (pick_winner_s)
  );

  // While ACTIVE, select holds the current owner.
  // Derive beat acceptance and the end-of-burst condition from it.
  always_comb begin
    owner_s     = select_q[PTR_W-1:0];
    beat_acc_s  = out_valid_q & out_ready;
    burst_end_s = beat_acc_s &
                  (((beat_cnt_q + 4'd1) == MAX_BURST_C) | ~req[owner_s]);
  end

  // Arbitration FSM with registered select, grant and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      select_q    <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ptr_q       <= '0;
      beat_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any_s) begin
            select_q    <= {1'b0, pick_winner_s};
            grant_q     <= ONE_HOT0 << pick_winner_s;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            beat_cnt_q  <= '0;
            state_q     <= ACTIVE;
          end else begin
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        ACTIVE: begin
          if (burst_end_s) begin
            beat_cnt_q  <= beat_cnt_q + 4'd1;
            ptr_q       <= owner_s + 5'd1;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else if (beat_acc_s) begin
            beat_cnt_q  <= beat_cnt_q + 4'd1;
          end else begin
            beat_cnt_q  <= beat_cnt_q;
          end
        end
        default: begin
          state_q     <= IDLE;
          grant_q     <= '0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign select    = select_q;
  assign grant     = grant_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
